// File: rtl/mono_data_rx_mc.sv
// mono_data_rx_mc: multi-channel MONOPIX serial data receiver.
// Serves up to four token/data/read lanes round-robin on a single clock.
// For the selected lane it runs the freeze/read/serial-shift handshake.
// It then packs each hit into a tagged 32-bit word in a first-word-fall-through FIFO.
// Optional feature macro: MONO_RX_TS_EN (adds a timestamp word after every hit word).
module mono_data_rx_mc #(
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned DATA_BITS  = 26,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [1:0]  IDENTIFIER = 2'b00
) (
  input  logic                BUS_CLK,
  input  logic                BUS_RST_N,
  input  logic                CONF_EN,
  input  logic [CHANNELS-1:0] CONF_CH_MASK,
  input  logic [3:0]          CONF_DIV,
  input  logic [63:0]         TIMESTAMP,
  input  logic [CHANNELS-1:0] RX_TOKEN,
  input  logic [CHANNELS-1:0] RX_DATA,
  output logic                RX_CLK,
  output logic                RX_FREEZE,
  output logic [CHANNELS-1:0] RX_READ,
  input  logic                FIFO_READ,
  output logic                FIFO_EMPTY,
  output logic [31:0]         FIFO_DATA,
  output logic [7:0]          LOST_COUNT,
  output logic                BUSY
);

  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam int unsigned CW       = AW + 1;
  localparam logic [4:0]  LAST_BIT = 5'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FREEZE, S_READ, S_SHIFT, S_STORE, S_SETTLE
  } state_t;

  state_t              state_q, state_d;
  logic [CHANNELS-1:0] tok_s1_q, tok_s2_q;
  logic [CHANNELS-1:0] req;
  logic [5:0]          cnt_q, cnt_d;
  logic [4:0]          bit_q, bit_d;
  logic [1:0]          ch_q, ch_d, last_q, last_d;
  logic [DATA_BITS-1:0] sr_q, sr_d;
  logic                rx_clk_q, rx_clk_d;
  logic                freeze_q, freeze_d;
  logic                busy_q, busy_d;
  logic [CHANNELS-1:0] read_q, read_d;
  logic [7:0]          lost_q, lost_d;
  logic [5:0]          h, two_h;
  logic [1:0]          rr_sel;
  logic                rr_found;
  int unsigned         idx;
  logic                rx_bit;
  logic [26:0]         hit_data27;
  logic [31:0]         hit_word;
  logic                wr_en;
  logic [31:0]         wr_data;

  logic [31:0]         mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]       fcnt_q, fcnt_d;
  logic                do_rd;
  logic [31:0]         head;
  logic                empty_q, empty_d;
  logic [31:0]         fdata_q, fdata_d;

`ifdef MONO_RX_TS_EN
  logic [26:0]         ts_q, ts_d;
  logic                store_ok_q, store_ok_d;
  logic [31:0]         ts_word;
  logic                unused_ts;
  assign unused_ts = ^TIMESTAMP[63:27];
`else
  logic                unused_ts;
  assign unused_ts = ^TIMESTAMP;
`endif

  // Round-robin pick of the next requesting lane after the last one served
  always_comb begin
    req      = tok_s2_q & CONF_CH_MASK;
    rr_sel   = last_q;
    rr_found = 1'b0;
    idx      = 0;
    for (int unsigned i = 1; i <= CHANNELS; i++) begin
      idx = (32'(last_q) + i) % CHANNELS;
      for (int unsigned j = 0; j < CHANNELS; j++) begin
        if (!rr_found && (j == idx) && req[j]) begin
          rr_found = 1'b1;
          rr_sel   = 2'(j);
        end
      end
    end
  end

  // Serial bit of the selected lane and the packed hit word
  always_comb begin
    rx_bit = 1'b0;
    for (int unsigned j = 0; j < CHANNELS; j++) begin
      if (32'(ch_q) == j) rx_bit = RX_DATA[j];
    end
    hit_data27                  = '0;
    hit_data27[DATA_BITS-1:0]   = sr_q;
    hit_word                    = {IDENTIFIER, 1'b0, ch_q, hit_data27};
`ifdef MONO_RX_TS_EN
    ts_word                     = {IDENTIFIER, 1'b1, ch_q, ts_q};
`endif
  end

  // Readout sequencer: next state, counters, FIFO write request, registered outputs
  always_comb begin
    h        = {2'b00, CONF_DIV} + 6'd1;
    two_h    = {h[4:0], 1'b0};
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    ch_d     = ch_q;
    last_d   = last_q;
    sr_d     = sr_q;
    lost_d   = lost_q;
    wr_en    = 1'b0;
    wr_data  = hit_word;
`ifdef MONO_RX_TS_EN
    store_ok_d = store_ok_q;
    ts_d       = ts_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (CONF_EN && rr_found) begin
          ch_d    = rr_sel;
          last_d  = rr_sel;
          state_d = S_FREEZE;
          cnt_d   = '0;
        end
      end
      S_FREEZE: begin
        if (cnt_q == two_h - 6'd1) begin
          state_d = S_READ;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_READ: begin
        if (cnt_q == two_h - 6'd1) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_SHIFT: begin
        if (cnt_q == h - 6'd1) sr_d = (sr_q << 1) | DATA_BITS'(rx_bit);
        if (cnt_q == two_h - 6'd1) begin
          cnt_d = '0;
          if (bit_q == LAST_BIT) state_d = S_STORE;
          else                   bit_d   = bit_q + 5'd1;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_STORE: begin
`ifdef MONO_RX_TS_EN
        // Space for the whole pair is reserved in the first cycle so the
        // timestamp word can never land without its hit word.
        if (cnt_q == '0) begin
          if (fcnt_q <= CW'(FIFO_DEPTH - 2)) begin
            wr_en      = 1'b1;
            store_ok_d = 1'b1;
          end else begin
            store_ok_d = 1'b0;
            lost_d     = (lost_q == 8'hFF) ? lost_q : lost_q + 8'd1;
          end
          cnt_d = 6'd1;
        end else begin
          wr_en   = store_ok_q;
          wr_data = ts_word;
          state_d = S_SETTLE;
          cnt_d   = '0;
        end
`else
        if (fcnt_q == CW'(FIFO_DEPTH)) lost_d = (lost_q == 8'hFF) ? lost_q : lost_q + 8'd1;
        else                           wr_en  = 1'b1;
        state_d = S_SETTLE;
        cnt_d   = '0;
`endif
      end
      S_SETTLE: begin
        if (cnt_q == 6'd3) begin
          cnt_d = '0;
          if (CONF_EN && rr_found) begin
            ch_d    = rr_sel;
            last_d  = rr_sel;
            state_d = S_READ;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef MONO_RX_TS_EN
    if (state_d == S_READ && state_q != S_READ) ts_d = TIMESTAMP[26:0];
`endif
    rx_clk_d = (state_d == S_SHIFT) && (cnt_d < h);
    busy_d   = (state_d != S_IDLE);
    freeze_d = (state_d != S_IDLE);
    read_d   = '0;
    for (int unsigned j = 0; j < CHANNELS; j++) begin
      read_d[j] = (state_d == S_READ) && (32'(ch_d) == j);
    end
  end

  // FIFO pointers, occupancy and registered head word
  always_comb begin
    do_rd = FIFO_READ && (fcnt_q != '0);
    wp_d  = wr_en ? wp_q + 1'b1 : wp_q;
    rp_d  = do_rd ? rp_q + 1'b1 : rp_q;
    case ({wr_en, do_rd})
      2'b10:   fcnt_d = fcnt_q + 1'b1;
      2'b01:   fcnt_d = fcnt_q - 1'b1;
      default: fcnt_d = fcnt_q;
    endcase
    // The slot being written this cycle becomes the head only when it is the
    // sole entry left, so it is forwarded instead of read from storage.
    head    = (wr_en && (rp_d == wp_q)) ? wr_data : mem_q[rp_d];
    empty_d = (fcnt_d == '0);
    fdata_d = empty_d ? '0 : head;
  end

  // FIFO storage
  always_ff @(posedge BUS_CLK) begin
    if (wr_en) mem_q[wp_q] <= wr_data;
  end

  // State, synchroniser and output registers
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      state_q  <= S_IDLE;
      tok_s1_q <= '0;
      tok_s2_q <= '0;
      cnt_q    <= '0;
      bit_q    <= '0;
      ch_q     <= '0;
      last_q   <= 2'(CHANNELS - 1);
      sr_q     <= '0;
      rx_clk_q <= 1'b0;
      freeze_q <= 1'b0;
      busy_q   <= 1'b0;
      read_q   <= '0;
      lost_q   <= '0;
      wp_q     <= '0;
      rp_q     <= '0;
      fcnt_q   <= '0;
      empty_q  <= 1'b1;
      fdata_q  <= '0;
`ifdef MONO_RX_TS_EN
      ts_q       <= '0;
      store_ok_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      tok_s1_q <= RX_TOKEN;
      tok_s2_q <= tok_s1_q;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      ch_q     <= ch_d;
      last_q   <= last_d;
      sr_q     <= sr_d;
      rx_clk_q <= rx_clk_d;
      freeze_q <= freeze_d;
      busy_q   <= busy_d;
      read_q   <= read_d;
      lost_q   <= lost_d;
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      fcnt_q   <= fcnt_d;
      empty_q  <= empty_d;
      fdata_q  <= fdata_d;
`ifdef MONO_RX_TS_EN
      ts_q       <= ts_d;
      store_ok_q <= store_ok_d;
`endif
    end
  end

  assign RX_CLK     = rx_clk_q;
  assign RX_FREEZE  = freeze_q;
  assign RX_READ    = read_q;
  assign BUSY       = busy_q;
  assign LOST_COUNT = lost_q;
  assign FIFO_EMPTY = empty_q;
  assign FIFO_DATA  = fdata_q;

endmodule

// File: tb/tb_mono_data_rx_mc.sv
// Directed bench for mono_data_rx_mc with a behavioural chip model per lane.
module tb_mono_data_rx_mc;

`ifdef MONO_RX_TS_EN
  localparam int TSX = 1;
`else
  localparam int TSX = 0;
`endif

  logic        BUS_CLK = 1'b0;
  logic        BUS_RST_N = 1'b0;
  logic        CONF_EN = 1'b0;
  logic [3:0]  CONF_CH_MASK = 4'hF;
  logic [3:0]  CONF_DIV = 4'h0;
  logic [63:0] TIMESTAMP = 64'h0;
  logic [3:0]  RX_TOKEN;
  logic [3:0]  RX_DATA;
  logic        RX_CLK, RX_FREEZE, BUSY, FIFO_EMPTY;
  logic [3:0]  RX_READ;
  logic        FIFO_READ = 1'b0;
  logic [31:0] FIFO_DATA;
  logic [7:0]  LOST_COUNT;

  mono_data_rx_mc #(
    .CHANNELS(4), .DATA_BITS(26), .FIFO_DEPTH(4), .IDENTIFIER(2'b00)
  ) dut (
    .BUS_CLK(BUS_CLK), .BUS_RST_N(BUS_RST_N), .CONF_EN(CONF_EN),
    .CONF_CH_MASK(CONF_CH_MASK), .CONF_DIV(CONF_DIV), .TIMESTAMP(TIMESTAMP),
    .RX_TOKEN(RX_TOKEN), .RX_DATA(RX_DATA), .RX_CLK(RX_CLK),
    .RX_FREEZE(RX_FREEZE), .RX_READ(RX_READ), .FIFO_READ(FIFO_READ),
    .FIFO_EMPTY(FIFO_EMPTY), .FIFO_DATA(FIFO_DATA), .LOST_COUNT(LOST_COUNT),
    .BUSY(BUSY)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  // Chip model: pending hits raise the token, a read pulse loads the hit and
  // drops one pending request, each RX_CLK rise presents the next bit MSB first.
  int          req    [4] = '{default: 0};
  int          served [4] = '{default: 0};
  logic [25:0] hit_mem [4][8];
  logic [25:0] chip_sr = '0;
  int          chip_sel = 0;
  logic [3:0]  read_prev = '0;
  logic        clk_prev = 1'b0;

  always @(negedge BUS_CLK) begin
    for (int c = 0; c < 4; c++) begin
      if (RX_READ[c] && !read_prev[c]) begin
        chip_sr   = hit_mem[c][served[c] & 7];
        chip_sel  = c;
        served[c] = served[c] + 1;
      end
    end
    read_prev = RX_READ;
    if (RX_CLK && !clk_prev) begin
      RX_DATA           = '0;
      RX_DATA[chip_sel] = chip_sr[25];
      chip_sr           = chip_sr << 1;
    end
    clk_prev = RX_CLK;
    for (int c = 0; c < 4; c++) RX_TOKEN[c] = (req[c] != served[c]);
  end

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          ch;
    logic [3:0]  div;
    logic [25:0] data;
    logic [31:0] exp_word;
    int          exp_cyc;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push(input int ch, input logic [25:0] data);
    hit_mem[ch][req[ch] & 7] = data;
    req[ch] = req[ch] + 1;
  endtask

  task automatic pop_check(input string name, input logic [31:0] exp);
    check({name, "_empty"}, FIFO_EMPTY, 1'b0);
    check({name, "_data"}, FIFO_DATA, exp);
    FIFO_READ = 1'b1;
    @(negedge BUS_CLK);
    FIFO_READ = 1'b0;
  endtask

  // Pops a hit word and, with the timestamp build, its timestamp word.
  task automatic pop_hit(input string name, input int ch, input logic [31:0] exp_word,
                         input logic [26:0] ts);
    logic [31:0] tsw;
    pop_check({name, "_hit"}, exp_word);
    tsw = 32'h2000_0000 | (32'(ch) << 27) | 32'(ts);
    if (TSX == 1) pop_check({name, "_ts"}, tsw);
  endtask

  // Waits for a busy window, counts its cycles and the lanes read in it.
  task automatic run_wait(input string name, input int exp_cyc, input logic [3:0] exp_rd);
    int n;
    int cyc;
    logic [3:0] rd_seen;
    n = 0;
    while (!BUSY && n < 40) begin
      @(negedge BUS_CLK);
      n++;
    end
    check({name, "_busy_rise"}, BUSY, 1'b1);
    cyc = 0;
    n = 0;
    rd_seen = '0;
    while (BUSY && n < 4000) begin
      if (RX_FREEZE) cyc++;
      rd_seen = rd_seen | RX_READ;
      @(negedge BUS_CLK);
      n++;
    end
    check({name, "_cycles"}, 64'(cyc), 64'(exp_cyc));
    check({name, "_reads"}, rd_seen, exp_rd);
    check({name, "_freeze_low"}, RX_FREEZE, 1'b0);
  endtask

  initial begin
    int n;
    logic seen;

    vecs[0] = '{ch: 2, div: 4'd0,  data: 26'h3FFFFFF, exp_word: 32'h13FF_FFFF, exp_cyc: 61};
    vecs[1] = '{ch: 1, div: 4'd1,  data: 26'h1234567, exp_word: 32'h0923_4567, exp_cyc: 117};
    vecs[2] = '{ch: 3, div: 4'd2,  data: 26'h0000001, exp_word: 32'h1800_0001, exp_cyc: 173};
    vecs[3] = '{ch: 0, div: 4'd15, data: 26'h2000000, exp_word: 32'h0200_0000, exp_cyc: 901};
    vecs[4] = '{ch: 3, div: 4'd0,  data: 26'h2AAAAAA, exp_word: 32'h1AAA_AAAA, exp_cyc: 61};
    vecs[5] = '{ch: 1, div: 4'd0,  data: 26'h0000000, exp_word: 32'h0800_0000, exp_cyc: 61};

    // Reset values
    repeat (3) @(negedge BUS_CLK);
    check("rst_rx_clk", RX_CLK, 1'b0);
    check("rst_freeze", RX_FREEZE, 1'b0);
    check("rst_read", RX_READ, 4'h0);
    check("rst_busy", BUSY, 1'b0);
    check("rst_empty", FIFO_EMPTY, 1'b1);
    check("rst_data", FIFO_DATA, 32'h0);
    check("rst_lost", LOST_COUNT, 8'h0);
    BUS_RST_N = 1'b1;
    CONF_EN   = 1'b1;
    repeat (2) @(negedge BUS_CLK);

    // Single hit on ch0 with token-to-freeze latency
    @(posedge BUS_CLK); #1;
    push(0, 26'h2ABCDEF);
    repeat (3) @(negedge BUS_CLK);
    check("single_lat_early", RX_FREEZE, 1'b0);
    @(negedge BUS_CLK);
    check("single_lat_freeze", RX_FREEZE, 1'b1);
    run_wait("single", 61 + TSX, 4'b0001);
    pop_hit("single", 0, 32'h02AB_CDEF, 27'h0);
    check("single_empty_after", FIFO_EMPTY, 1'b1);

    // ch1 and ch3 together: one freeze window, ch1 first
    @(posedge BUS_CLK); #1;
    push(1, 26'h1111111);
    push(3, 26'h30F0F0F);
    run_wait("dual", 120 + 2 * TSX, 4'b1010);
    pop_hit("dual_a", 1, 32'h0911_1111, 27'h0);
    pop_hit("dual_b", 3, 32'h1B0F_0F0F, 27'h0);
    check("dual_empty_after", FIFO_EMPTY, 1'b1);

    // Table of single hits over several dividers and lanes
    for (int i = 0; i < 6; i++) begin
      CONF_DIV = vecs[i].div;
      @(posedge BUS_CLK); #1;
      push(vecs[i].ch, vecs[i].data);
      run_wait($sformatf("vec%0d", i), vecs[i].exp_cyc + TSX, 4'(1 << vecs[i].ch));
      pop_hit($sformatf("vec%0d", i), vecs[i].ch, vecs[i].exp_word, 27'h0);
    end
    CONF_DIV = 4'd0;

    // Masked lane stays idle until unmasked
    CONF_CH_MASK = 4'b1110;
    @(posedge BUS_CLK); #1;
    push(0, 26'h0C0FFEE);
    seen = 1'b0;
    repeat (80) begin
      @(negedge BUS_CLK);
      seen = seen | BUSY | RX_FREEZE;
    end
    check("mask_no_busy", seen, 1'b0);
    check("mask_empty", FIFO_EMPTY, 1'b1);
    CONF_CH_MASK = 4'hF;
    run_wait("mask_release", 61 + TSX, 4'b0001);
    pop_hit("mask_release", 0, 32'h00C0_FFEE, 27'h0);

    // FIFO overflow: six hits, no reads
    @(posedge BUS_CLK); #1;
    for (int k = 0; k < 6; k++) push(2, 26'h1000000 | 26'(k));
    n = 0;
    while ((served[2] != req[2] || BUSY || !FIFO_EMPTY && n == 0) && n < 3000) begin
      @(negedge BUS_CLK);
      n++;
    end
    check("full_all_read", 64'(served[2]), 64'(req[2]));
    check("full_idle", BUSY, 1'b0);
    check("full_token_clear", RX_TOKEN, 4'h0);
    if (TSX == 1) begin
      check("full_lost", LOST_COUNT, 8'd4);
      pop_hit("full0", 2, 32'h1100_0000, 27'h0);
      pop_hit("full1", 2, 32'h1100_0001, 27'h0);
    end else begin
      check("full_lost", LOST_COUNT, 8'd2);
      for (int k = 0; k < 4; k++) pop_check($sformatf("full%0d", k), 32'h1100_0000 | 32'(k));
    end
    check("full_empty_after", FIFO_EMPTY, 1'b1);

    // Reset in the middle of the serial shift
    CONF_DIV = 4'd3;
    @(posedge BUS_CLK); #1;
    push(1, 26'h0155555);
    n = 0;
    while (!RX_CLK && n < 300) begin
      @(negedge BUS_CLK);
      n++;
    end
    check("rstmid_in_shift", RX_CLK, 1'b1);
    BUS_RST_N = 1'b0;
    #1;
    check("rstmid_rx_clk", RX_CLK, 1'b0);
    check("rstmid_freeze", RX_FREEZE, 1'b0);
    check("rstmid_read", RX_READ, 4'h0);
    check("rstmid_busy", BUSY, 1'b0);
    check("rstmid_empty", FIFO_EMPTY, 1'b1);
    check("rstmid_data", FIFO_DATA, 32'h0);
    check("rstmid_lost", LOST_COUNT, 8'h0);
    repeat (2) @(negedge BUS_CLK);
    BUS_RST_N = 1'b1;
    CONF_DIV  = 4'd0;
    repeat (2) @(negedge BUS_CLK);
    @(posedge BUS_CLK); #1;
    push(0, 26'h0ABCDEF);
    repeat (3) @(negedge BUS_CLK);
    check("rstmid_lat_early", RX_FREEZE, 1'b0);
    @(negedge BUS_CLK);
    check("rstmid_lat_freeze", RX_FREEZE, 1'b1);
    run_wait("rstmid_clean", 61 + TSX, 4'b0001);
    pop_hit("rstmid_clean", 0, 32'h00AB_CDEF, 27'h0);

`ifdef MONO_RX_TS_EN
    // Timestamp word latched on entry to READ
    TIMESTAMP = 64'h123;
    @(posedge BUS_CLK); #1;
    push(2, 26'h0000ABC);
    run_wait("ts", 62, 4'b0100);
    pop_check("ts_hit", 32'h1000_0ABC);
    pop_check("ts_ts", 32'h3000_0123);
    TIMESTAMP = 64'h0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
